// File: rtl/pep_ks_common_definition_pkg.sv
// Shared key-switch geometry: lane counts, gadget decomposition shape and digit types.
// Latency: n/a (definitions only).
// Backpressure: n/a.
package pep_ks_common_definition_pkg;

    // Key-switch array geometry.
    localparam int LBY = 64;
    localparam int LBZ = 3;

    // Gadget decomposition shape.
    localparam int KS_B_W   = 4;
    localparam int KS_LEVEL = 5;

    // Levels are emitted LBZ at a time, so one coefficient spans NGRP output beats.
    localparam int NGRP  = (KS_LEVEL + LBZ - 1) / LBZ;
    localparam int GRP_W = (NGRP > 1) ? $clog2(NGRP) : 1;

    typedef logic [KS_B_W-1:0]  digit_t;
    typedef digit_t [KS_LEVEL-1:0] decomp_t;

    // Group-counter states of the decomposer output stage.
    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_FULL = 1'b1
    } ks_decomp_state_t;

endpackage

// File: rtl/pep_ks_decomp_coef.sv
// Rounds one coefficient to KS_LEVEL*KS_B_W bits and splits it into KS_LEVEL digits (level 0 = LSB).
// Latency: purely combinational.
// Backpressure: none; PEP_KS_DECOMP_BALANCED_EN selects signed balanced digits, else plain unsigned digits.
module pep_ks_decomp_coef #(
    parameter int MOD_Q_W  = 64,
    parameter int KS_B_W   = 4,
    parameter int KS_LEVEL = 5
) (
    input  logic [MOD_Q_W-1:0]         coef,
    output logic [KS_LEVEL*KS_B_W-1:0] digits
);

    localparam int RW = KS_LEVEL * KS_B_W;

    logic [RW-1:0] r;

    // Adding half an LSB of the kept field and truncating only ever carries in through the
    // bit just below the field, so the rounding reduces to adding that single bit to the top bits.
    generate
        if (RW == MOD_Q_W) begin : g_no_round
            assign r = coef;
        end else if (RW == MOD_Q_W - 1) begin : g_round_exact
            assign r = coef[MOD_Q_W-1 -: RW] + {{(RW-1){1'b0}}, coef[0]};
        end else begin : g_round
            logic unused_low_bits;
            assign r = coef[MOD_Q_W-1 -: RW] + {{(RW-1){1'b0}}, coef[MOD_Q_W-RW-1]};
            assign unused_low_bits = ^coef[MOD_Q_W-RW-2:0];
        end
    endgenerate

`ifdef PEP_KS_DECOMP_BALANCED_EN
    localparam logic [KS_B_W:0] HALF_B = (KS_B_W+1)'(1) << (KS_B_W - 1);

    // Carry chain LSB level first. The stored digit bits are d mod B whether or not the
    // digit is recentred, since subtracting B only changes bits above KS_B_W; the recentring
    // shows up purely as the carry into the next level. The top carry falls off the end.
    always_comb begin
        logic              c;
        logic [KS_B_W:0]   d;
        c      = 1'b0;
        d      = '0;
        digits = '0;
        for (int l = 0; l < KS_LEVEL; l++) begin
            d = {1'b0, r[l*KS_B_W +: KS_B_W]} + {{KS_B_W{1'b0}}, c};
            digits[l*KS_B_W +: KS_B_W] = d[KS_B_W-1:0];
            c = (d >= HALF_B);
        end
    end
`else
    // Unsigned digits are just the rounded value sliced into KS_B_W-bit fields.
    assign digits = r;
`endif

endmodule

// File: rtl/pep_ks_decomp.sv
// Gadget decomposer: digits all LBY coefficients of a beat, then streams them LBZ levels per output beat.
// Latency: 1 cycle from input acceptance to group 0; NGRP output beats per input beat.
// Backpressure: outputs held while out_ready=0; in_ready refills combinationally on the final group handshake.
// Digit style: PEP_KS_DECOMP_BALANCED_EN defined -> balanced signed digits, undefined -> unsigned digits.
module pep_ks_decomp
    import pep_ks_common_definition_pkg::LBY,
           pep_ks_common_definition_pkg::LBZ,
           pep_ks_common_definition_pkg::ks_decomp_state_t,
           pep_ks_common_definition_pkg::ST_IDLE,
           pep_ks_common_definition_pkg::ST_FULL;
#(
    parameter int  MOD_Q_W  = 64,
    parameter int  KS_B_W   = 4,
    parameter int  KS_LEVEL = 5,
    localparam int NGRP     = (KS_LEVEL + LBZ - 1) / LBZ,
    localparam int GRP_W    = (NGRP > 1) ? $clog2(NGRP) : 1
) (
    input  logic                        clk,
    input  logic                        s_rst_n,
    input  logic [LBY*MOD_Q_W-1:0]      in_data,
    input  logic                        in_last,
    input  logic                        in_valid,
    output logic                        in_ready,
    output logic [LBY*LBZ*KS_B_W-1:0]   out_data,
    output logic [GRP_W-1:0]            out_group,
    output logic                        out_last,
    output logic                        out_valid,
    input  logic                        out_ready
);

    localparam int               DW     = KS_LEVEL * KS_B_W;
    localparam logic [GRP_W-1:0] LAST_G = GRP_W'(NGRP - 1);

    ks_decomp_state_t        state;
    logic [GRP_W-1:0]        grp;
    logic                    last_q;
    logic [LBY*DW-1:0]       dig_buf;
    logic [LBY*DW-1:0]       dig_comb;
    logic                    accept;
    logic                    final_grp;

    // One combinational decomposer per lane, evaluated on the beat being presented.
    for (genvar i = 0; i < LBY; i++) begin : g_lane
        pep_ks_decomp_coef #(
            .MOD_Q_W  (MOD_Q_W),
            .KS_B_W   (KS_B_W),
            .KS_LEVEL (KS_LEVEL)
        ) u_coef (
            .coef   (in_data[i*MOD_Q_W +: MOD_Q_W]),
            .digits (dig_comb[i*DW +: DW])
        );
    end

    assign final_grp = (grp == LAST_G);
    assign out_valid = (state == ST_FULL);
    assign out_group = grp;
    assign out_last  = last_q & final_grp;
    // The buffer can take a new beat in the same cycle its last group leaves, so no bubble.
    assign in_ready  = !out_valid | (out_ready & final_grp);
    assign accept    = in_valid & in_ready;

    // Group counter FSM: load the digit buffer on accept, step groups on each output handshake.
    always_ff @(posedge clk or negedge s_rst_n) begin
        if (!s_rst_n) begin
            state   <= ST_IDLE;
            grp     <= '0;
            last_q  <= 1'b0;
            dig_buf <= '0;
        end else if (accept) begin
            state   <= ST_FULL;
            grp     <= '0;
            last_q  <= in_last;
            dig_buf <= dig_comb;
        end else if (state == ST_FULL && out_ready) begin
            if (final_grp) begin
                state  <= ST_IDLE;
                grp    <= '0;
                last_q <= 1'b0;
            end else begin
                grp <= grp + 1'b1;
            end
        end
    end

    // Select levels grp*LBZ .. grp*LBZ+LBZ-1 of each lane; levels past KS_LEVEL are zero padding.
    always_comb begin
        out_data = '0;
        for (int i = 0; i < LBY; i++) begin
            for (int z = 0; z < LBZ; z++) begin
                int lvl;
                lvl = int'(grp) * LBZ + z;
                if (lvl < KS_LEVEL) begin
                    out_data[(i*LBZ+z)*KS_B_W +: KS_B_W] = dig_buf[(i*KS_LEVEL+lvl)*KS_B_W +: KS_B_W];
                end
            end
        end
    end

endmodule

// File: tb/tb_pep_ks_decomp.sv
// Directed bench for pep_ks_decomp: hand-computed digit vectors, back-to-back flow, stall and reset.
// Latency: checks group 0 one cycle after acceptance.
// Backpressure: holds out_ready low mid-beat and checks outputs stay put.
module tb_pep_ks_decomp;
    import pep_ks_common_definition_pkg::*;

    localparam int QW = 64;
    localparam int GW = LBZ * KS_B_W;

    logic                      clk = 1'b0;
    logic                      s_rst_n;
    logic [LBY*QW-1:0]         in_data;
    logic                      in_last;
    logic                      in_valid;
    logic                      in_ready;
    logic [LBY*LBZ*KS_B_W-1:0] out_data;
    logic [GRP_W-1:0]          out_group;
    logic                      out_last;
    logic                      out_valid;
    logic                      out_ready;

    int n_vec = 0;
    int n_err = 0;

    // Input coefficients and their hand-derived digits (level l at e[l]).
    localparam logic [63:0] C_7     = 64'h0000_7000_0000_0000;
    localparam logic [63:0] C_8     = 64'h0000_8000_0000_0000;
    localparam logic [63:0] C_TOP   = 64'h8000_0000_0000_0000;
    localparam logic [63:0] C_ONES  = 64'hFFFF_FFFF_FFFF_FFFF;
    localparam logic [63:0] C_RUP   = 64'h0000_0800_0000_0000;
    localparam logic [63:0] C_MIX   = 64'hABCD_E000_0000_0000;
    localparam decomp_t     E_7     = 20'h00007;
    localparam decomp_t     E_TOP   = 20'h80000;
    localparam decomp_t     E_ZERO  = 20'h00000;
    localparam decomp_t     E_RUP   = 20'h00001;
`ifdef PEP_KS_DECOMP_BALANCED_EN
    localparam decomp_t     E_8     = 20'h00018;
    localparam decomp_t     E_MIX   = 20'hBCDEE;
`else
    localparam decomp_t     E_8     = 20'h00008;
    localparam decomp_t     E_MIX   = 20'hABCDE;
`endif

    pep_ks_decomp dut (
        .clk       (clk),
        .s_rst_n   (s_rst_n),
        .in_data   (in_data),
        .in_last   (in_last),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out_data  (out_data),
        .out_group (out_group),
        .out_last  (out_last),
        .out_valid (out_valid),
        .out_ready (out_ready)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [LBY*QW-1:0] fill(input logic [63:0] c);
        logic [LBY*QW-1:0] v;
        for (int i = 0; i < LBY; i++) v[i*QW +: QW] = c;
        return v;
    endfunction

    function automatic logic [GW-1:0] grp_exp(input decomp_t e, input int g);
        logic [GW-1:0] v;
        v = '0;
        for (int z = 0; z < LBZ; z++) begin
            if (g * LBZ + z < KS_LEVEL) v[z*KS_B_W +: KS_B_W] = e[g*LBZ+z];
        end
        return v;
    endfunction

    function automatic logic [GW-1:0] lane(input int i);
        return out_data[i*GW +: GW];
    endfunction

    // One isolated beat: accept, check both groups on lanes 0 and LBY-1, then idle.
    task automatic run_beat(input string tag, input logic [63:0] c, input decomp_t e, input logic last);
        @(negedge clk);
        in_data = fill(c); in_last = last; in_valid = 1'b1; out_ready = 1'b1;
        chk({tag, ".in_rdy"}, 64'(in_ready), 64'd1);
        @(negedge clk);
        in_valid = 1'b0;
        chk({tag, ".g0.vld"}, 64'(out_valid), 64'd1);
        chk({tag, ".g0.grp"}, 64'(out_group), 64'd0);
        chk({tag, ".g0.l0"},  64'(lane(0)), 64'(grp_exp(e, 0)));
        chk({tag, ".g0.lN"},  64'(lane(LBY-1)), 64'(grp_exp(e, 0)));
        chk({tag, ".g0.last"}, 64'(out_last), 64'd0);
        @(negedge clk);
        chk({tag, ".g1.grp"}, 64'(out_group), 64'd1);
        chk({tag, ".g1.l0"},  64'(lane(0)), 64'(grp_exp(e, 1)));
        chk({tag, ".g1.last"}, 64'(out_last), 64'(last));
        @(negedge clk);
        chk({tag, ".idle"}, 64'(out_valid), 64'd0);
    endtask

    initial begin
        s_rst_n = 1'b0; in_data = '0; in_last = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst.vld",  64'(out_valid), 64'd0);
        chk("rst.grp",  64'(out_group), 64'd0);
        chk("rst.last", 64'(out_last),  64'd0);
        chk("rst.data", 64'(|out_data), 64'd0);
        s_rst_n = 1'b1;
        @(negedge clk);
        chk("rst.in_rdy", 64'(in_ready), 64'd1);

        // Directed digit vectors.
        run_beat("c7",   C_7,    E_7,    1'b1);
        run_beat("c7nl", C_7,    E_7,    1'b0);
        run_beat("c8",   C_8,    E_8,    1'b0);
        run_beat("top",  C_TOP,  E_TOP,  1'b1);
        run_beat("ones", C_ONES, E_ZERO, 1'b0);
        run_beat("rup",  C_RUP,  E_RUP,  1'b0);
        run_beat("mix",  C_MIX,  E_MIX,  1'b1);

        // Lane placement: one lane carries a different coefficient.
        @(negedge clk);
        in_data = fill(C_7); in_data[5*QW +: QW] = C_RUP; in_last = 1'b0; in_valid = 1'b1; out_ready = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        chk("lane.l5", 64'(lane(5)), 64'(grp_exp(E_RUP, 0)));
        chk("lane.l4", 64'(lane(4)), 64'(grp_exp(E_7, 0)));
        chk("lane.l6", 64'(lane(6)), 64'(grp_exp(E_7, 0)));
        repeat (2) @(negedge clk);

        // Back-to-back beats with no bubble.
        in_data = fill(C_RUP); in_last = 1'b0; in_valid = 1'b1; out_ready = 1'b1;
        chk("b2b.rdy0", 64'(in_ready), 64'd1);
        @(negedge clk);
        chk("b2b.a.g0",  64'(out_group), 64'd0);
        chk("b2b.a.l0",  64'(lane(0)), 64'(grp_exp(E_RUP, 0)));
        chk("b2b.rdy1",  64'(in_ready), 64'd0);
        in_data = fill(C_MIX); in_last = 1'b1;
        @(negedge clk);
        chk("b2b.a.g1",  64'(out_group), 64'd1);
        chk("b2b.a.last", 64'(out_last), 64'd0);
        chk("b2b.rdy2",  64'(in_ready), 64'd1);
        @(negedge clk);
        in_valid = 1'b0;
        chk("b2b.b.vld", 64'(out_valid), 64'd1);
        chk("b2b.b.g0",  64'(out_group), 64'd0);
        chk("b2b.b.l0",  64'(lane(0)), 64'(grp_exp(E_MIX, 0)));
        chk("b2b.rdy3",  64'(in_ready), 64'd0);
        @(negedge clk);
        chk("b2b.b.g1",  64'(out_group), 64'd1);
        chk("b2b.b.l0g1", 64'(lane(0)), 64'(grp_exp(E_MIX, 1)));
        chk("b2b.b.last", 64'(out_last), 64'd1);
        @(negedge clk);
        chk("b2b.idle",  64'(out_valid), 64'd0);

        // Stall on group 1, then reset while stalled.
        in_data = fill(C_MIX); in_last = 1'b1; in_valid = 1'b1; out_ready = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        out_ready = 1'b0;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            chk($sformatf("stall%0d.vld", k),  64'(out_valid), 64'd1);
            chk($sformatf("stall%0d.grp", k),  64'(out_group), 64'd1);
            chk($sformatf("stall%0d.l0", k),   64'(lane(0)), 64'(grp_exp(E_MIX, 1)));
            chk($sformatf("stall%0d.last", k), 64'(out_last), 64'd1);
            chk($sformatf("stall%0d.rdy", k),  64'(in_ready), 64'd0);
        end
        s_rst_n = 1'b0;
        #1;
        chk("mrst.vld",  64'(out_valid), 64'd0);
        chk("mrst.grp",  64'(out_group), 64'd0);
        chk("mrst.last", 64'(out_last),  64'd0);
        chk("mrst.data", 64'(|out_data), 64'd0);
        @(negedge clk);
        s_rst_n = 1'b1;
        #1;
        chk("mrst.in_rdy", 64'(in_ready), 64'd1);
        @(negedge clk);
        chk("mrst.idle", 64'(out_valid), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/pep_ks_decomp.md
# pep_ks_decomp

Balanced-digit gadget decomposer that feeds the key-switch multiply-accumulate array. Each accepted input beat carries LBY BLWE coefficients. The block rounds each coefficient to KS_LEVEL·KS_B_W bits, decomposes it into KS_LEVEL signed digits, and emits them as LBZ levels per output beat. When KS_LEVEL exceeds LBZ, one input beat produces several output beats (level groups). It sits directly upstream of the LBX×LBY×LBZ key-switch core and consumes the BLWE coefficient stream.

## Interface
Parameters:
- MOD_Q_W, 64: input coefficient width (power-of-2 modulus).
- KS_B_W, 4: decomposition base log2; B = 2^KS_B_W.
- KS_LEVEL, 5: number of decomposition levels; KS_LEVEL·KS_B_W ≤ MOD_Q_W.
- LBY, LBZ: from pep_ks_common_definition_pkg (64, 3).

Ports:
- clk  in  1  clock.
- s_rst_n  in  1  reset; asynchronous assert, active-low.
- in_data  in  LBY·MOD_Q_W  LBY coefficients; coefficient i at bits [i·MOD_Q_W +: MOD_Q_W].
- in_last  in  1  last beat of a BLWE; forwarded on the final group.
- in_valid  in  1  input valid.
- in_ready  out  1  input ready.
- out_data  out  LBY·LBZ·KS_B_W  signed digits; coefficient i, sub-level z at index (i·LBZ+z).
- out_group  out  GRP_W  level-group index g; levels g·LBZ .. g·LBZ+LBZ-1.
- out_last  out  1  in_last of the source beat, asserted only on the final group.
- out_valid  out  1  output valid.
- out_ready  in  1  output ready.

## Operation
- NGRP = ceil(KS_LEVEL/LBZ); GRP_W = max(1, clog2(NGRP)).
- Rounding: r = (coef + 2^(MOD_Q_W − KS_LEVEL·KS_B_W − 1)) mod 2^MOD_Q_W, then keep the top KS_LEVEL·KS_B_W bits. Overflow wraps silently.
- Digits are computed LSB level first:
  - d_l = r[l·KS_B_W +: KS_B_W] + c_l, with c_0 = 0.
  - If d_l ≥ B/2: d_l −= B and c_(l+1) = 1; otherwise c_(l+1) = 0.
  - The carry out of the top level is dropped.
  - Result range is [−B/2, B/2−1], two's complement, KS_B_W bits.
- Level 0 is least significant. Sub-levels with index ≥ KS_LEVEL (padding in the last group) output 0.
- All KS_LEVEL digits for all LBY coefficients are computed combinationally at input acceptance and registered in a digit buffer. Output groups are then muxed out of that buffer by a group counter.
- The group counter state machine has two states:
  - IDLE (buffer empty): accept input → LOAD_FULL with g = 0.
  - FULL: on out handshake, if g < NGRP−1 then g++. Otherwise the buffer is freed, or refilled in the same cycle if in_valid is high.

## Timing
- Latency is 1 cycle: a beat accepted at edge t gives out_valid=1 and group 0 after edge t.
- Throughput is one output beat per cycle. One input beat is accepted every NGRP cycles under no backpressure.
- in_ready = !out_valid | (out_ready & g == NGRP−1). This is combinational from out_ready, with no bubble between input beats.
- When out_valid=1 and out_ready=0, out_data, out_group and out_last are held stable.
- in_valid must not depend on in_ready. out_valid does not drop without a handshake.
- Reset values: out_valid=0, out_group=0, out_last=0, out_data=0, group counter=0. in_ready=1 after reset.
- Reset mid-operation discards the buffered beat; there is no partial output after release.

## Configuration
- PEP_KS_DECOMP_BALANCED_EN defined: balanced signed digits, as described above.
- Not defined: plain unsigned digits d_l = r[l·KS_B_W +: KS_B_W] in [0, B−1], with no carry chain. Port widths are unchanged; consumers treat digits as unsigned.

## Structure
- Add to pep_ks_common_definition_pkg:
  - KS_B_W, KS_LEVEL, NGRP, GRP_W.
  - typedef digit_t (logic [KS_B_W-1:0]).
  - typedef decomp_t (digit_t [KS_LEVEL-1:0]).
- One sub-module, pep_ks_decomp_coef: purely combinational rounding plus carry chain for a single coefficient, instantiated LBY times.

## Test plan
(All cases use MOD_Q_W=64, KS_B_W=4, KS_LEVEL=5, LBZ=3.)
- coef = 0x0000_7000_0000_0000 on all lanes → group 0 digits (7,0,0), group 1 (0,0,pad 0). out_last only on group 1 when in_last=1.
- coef = 0x0000_8000_0000_0000 → balanced: level0 = −8 (0x8), level1 = 1. Without the macro: level0 = 8, level1 = 0.
- coef = 0x8000_0000_0000_0000 → level4 = −8 with the top carry dropped; levels 0–3 = 0.
- coef = 0xFFFF_FFFF_FFFF_FFFF → rounding wraps, all digits 0. coef = 0x0000_0800_0000_0000 → rounds up, level0 = 1.
- Back-to-back input beats with out_ready=1 → output groups 0,1,0,1… with no bubble. in_ready is high every second cycle.
- out_ready low for 5 cycles mid-group-1, then s_rst_n pulsed → output held stable while stalled, then out_valid=0 immediately on reset and in_ready=1 after release.
